// File: rtl/spi_dac_pkg.sv
// Shared constants for the dual-channel 12-bit DAC SPI link: frame layout,
// control nibble bit positions and codes, and the responder FSM encoding.
package spi_dac_pkg;
  localparam int DacWidth = 16;
  localparam int DataBits = 12;

  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  localparam logic [3:0] CTRL_A = 4'b0011;
  localparam logic [3:0] CTRL_B = 4'b1011;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus history flop with rise/fall detect.
// Latency SyncStages clk to lvl_o; no backpressure.
module spi_sync_edge #(
  parameter int   SyncStages = 2,
  parameter logic RstVal     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= {SyncStages{RstVal}};
      hist_q <= RstVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      hist_q <= sync_q[SyncStages-1];
    end
  end

  assign lvl_o  = sync_q[SyncStages-1];
  assign rise_o = lvl_o & ~hist_q;
  assign fall_o = ~lvl_o & hist_q;
endmodule

// File: rtl/spi_dac_rx.sv
// Oversampling SPI responder for the dual-channel DAC; commits 16-bit frames.
// Latency cs rise to valid/err = SyncStages+2 clk; no backpressure (listen only).
module spi_dac_rx
  import spi_dac_pkg::*;
#(
  parameter int Width      = DacWidth,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sck_i,
  input  logic                cs_i,
  input  logic                mosi_i,
  output logic [Width-1:0]    data_o,
  output logic [DataBits-1:0] dcha_o,
  output logic [DataBits-1:0] dchb_o,
  output logic                ena_o,
  output logic                enb_o,
  output logic                gaina_o,
  output logic                gainb_o,
  output logic                valid_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [7:0]          cnt_o
);
  localparam logic [4:0] WidthCnt = 5'(Width);
  localparam logic [4:0] SyncCnt  = 5'(SyncStages);
  localparam logic [4:0] CntMax   = 5'd31;

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.SyncStages(SyncStages), .RstVal(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),
    .lvl_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SyncStages(SyncStages), .RstVal(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),
    .lvl_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SyncStages(SyncStages), .RstVal(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
    .lvl_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_edges = ^{sck_s, sck_fall, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_t           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [Width-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_ARM;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      // The bit counter doubles as a settle timer here: the synchronizers come
      // out of reset showing cs high, so wait until real cs has propagated.
      ST_ARM: begin
        if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + 5'd1;
        if (cs_s && (bit_cnt_q >= SyncCnt)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!cs_s) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d = ST_DONE;
        end else if (sck_rise) begin
          shreg_d = {shreg_q[Width-2:0], mosi_s};
          if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_ARM;
    endcase
  end

  logic in_done, commit;
  assign in_done = (state_q == ST_DONE);
  assign commit  = in_done && (bit_cnt_q == WidthCnt);
  assign busy_o  = (state_q == ST_SHIFT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o  <= '0;
      dcha_o  <= '0;
      dchb_o  <= '0;
      ena_o   <= 1'b0;
      enb_o   <= 1'b0;
      gaina_o <= 1'b0;
      gainb_o <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      cnt_o   <= '0;
    end else begin
      valid_o <= commit;
      err_o   <= in_done && !commit;
      if (commit) begin
        data_o <= shreg_q;
        cnt_o  <= cnt_o + 8'd1;
        if (shreg_q[CH_BIT]) begin
          dchb_o  <= shreg_q[DataBits-1:0];
          enb_o   <= shreg_q[SHDN_BIT];
          gainb_o <= shreg_q[GA_BIT];
        end else begin
          dcha_o  <= shreg_q[DataBits-1:0];
          ena_o   <= shreg_q[SHDN_BIT];
          gaina_o <= shreg_q[GA_BIT];
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_dac_rx.sv
// Bench for spi_dac_rx: drives SPI frames and compares against a frame-level DAC model.
module tb_spi_dac_rx;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic [15:0] data_o;
  logic [11:0] dcha_o, dchb_o;
  logic ena_o, enb_o, gaina_o, gainb_o, valid_o, err_o, busy_o;
  logic [7:0] cnt_o;

  spi_dac_rx #(.Width(16), .SyncStages(SYNC)) dut (
    .clk_i(clk), .rst_i(rst_n), .sck_i(sck), .cs_i(cs), .mosi_i(mosi),
    .data_o(data_o), .dcha_o(dcha_o), .dchb_o(dchb_o),
    .ena_o(ena_o), .enb_o(enb_o), .gaina_o(gaina_o), .gainb_o(gainb_o),
    .valid_o(valid_o), .err_o(err_o), .busy_o(busy_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_valid = 0, n_err = 0, last_valid_cyc = -1, last_err_cyc = -1;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
    if (err_o === 1'b1) begin n_err++; last_err_cyc = cyc; end
  end

  // Frame-level DAC model
  logic [15:0] m_data;
  logic [11:0] m_a, m_b;
  logic m_ena, m_enb, m_ga, m_gb;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_data = '0; m_a = '0; m_b = '0;
    m_ena = 0; m_enb = 0; m_ga = 0; m_gb = 0; m_cnt = '0;
  endtask

  // A frame commits only when exactly 16 bits were clocked; bit 15 picks the
  // channel, bit 13 is gain, bit 12 is the active-high enable.
  task automatic model_frame(input logic [31:0] bits, input int n);
    logic [15:0] f;
    if (n == 16) begin
      f = bits[15:0];
      m_data = f;
      m_cnt  = m_cnt + 8'd1;
      if (f[15]) begin m_b = f[11:0]; m_enb = f[12]; m_gb = f[13]; end
      else       begin m_a = f[11:0]; m_ena = f[12]; m_ga = f[13]; end
    end
  endtask

  function automatic logic [51:0] model_vec();
    return {m_data, m_a, m_b, m_ena, m_enb, m_ga, m_gb, m_cnt};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {data_o, dcha_o, dchb_o, ena_o, enb_o, gaina_o, gainb_o, cnt_o};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo, input int half);
    for (int i = hi; i >= lo; i--) begin
      mosi = bits[i];
      wait_clks(half);
      sck = 1'b1;
      wait_clks(half);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            output int rise_cyc);
    @(negedge clk);
    cs = 1'b0; sck = 1'b0;
    wait_clks(half);
    if (n > 0) shift_bits(bits, n - 1, 0, half);
    wait_clks(half);
    cs = 1'b1;
    rise_cyc = cyc;
    wait_clks(half);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    model_reset();
    wait_clks(3);
    checks++;
    if ({dut_vec(), valid_o, err_o, busy_o} !== 55'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h busy=%b v=%b e=%b, want all zero",
               dut_vec(), busy_o, valid_o, err_o);
    end
    rst_n = 1'b1;
    wait_clks(6);
    checks++;
    if (n_valid != 0 || n_err != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: valid=%0d err=%0d busy=%b, want 0 0 0", n_valid, n_err, busy_o);
    end
  endtask

  task automatic test_directed();
    int rc, v0, e0;
    logic [31:0] frames [2] = '{32'h34D9, 32'hB9B2};
    for (int k = 0; k < 2; k++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(frames[k], 16, 8, rc);
      model_frame(frames[k], 16);
      wait_clks(4);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL directed_regs[%0d]: got %h want %h", k, dut_vec(), model_vec());
      end
      checks++;
      if (n_valid - v0 != 1 || n_err != e0) begin
        failures++;
        $display("FAIL directed_pulses[%0d]: valid=%0d err=%0d want 1 0", k, n_valid - v0, n_err - e0);
      end
      checks++;
      if (last_valid_cyc - rc != SYNC + 2) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", k, last_valid_cyc - rc, SYNC + 2);
      end
    end
  endtask

  task automatic test_length_err();
    int rc, v0, e0;
    int lens [3] = '{12, 17, 0};
    for (int k = 0; k < 3; k++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(32'h1_5A5A, lens[k], 8, rc);
      model_frame(32'h1_5A5A, lens[k]);
      wait_clks(4);
      checks++;
      if (n_err - e0 != 1 || n_valid != v0) begin
        failures++;
        $display("FAIL len_err_pulses[%0d bits]: err=%0d valid=%0d want 1 0", lens[k], n_err - e0, n_valid - v0);
      end
      checks++;
      if (last_err_cyc - rc != SYNC + 2) begin
        failures++;
        $display("FAIL len_err_latency[%0d bits]: got %0d want %0d", lens[k], last_err_cyc - rc, SYNC + 2);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL len_err_regs[%0d bits]: got %h want %h", lens[k], dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_shutdown();
    int rc, v0;
    v0 = n_valid;
    send_frame(32'h2123, 16, 8, rc);
    model_frame(32'h2123, 16);
    wait_clks(4);
    checks++;
    if (dut_vec() !== model_vec() || n_valid - v0 != 1) begin
      failures++;
      $display("FAIL shutdown: got %h valid=%0d want %h valid=1", dut_vec(), n_valid - v0, model_vec());
    end
  endtask

  task automatic test_random();
    int rc, v0, e0, n, half;
    logic [31:0] bits;
    for (int k = 0; k < 24; k++) begin
      bits = $urandom;
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      half = $urandom_range(SYNC + 1, 8);
      v0 = n_valid; e0 = n_err;
      send_frame(bits, n, half, rc);
      model_frame(bits, n);
      wait_clks(6);
      checks++;
      if (dut_vec() !== model_vec()
          || n_valid - v0 != ((n == 16) ? 1 : 0)
          || n_err - e0 != ((n == 16) ? 0 : 1)) begin
        failures++;
        $display("FAIL random[%0d] n=%0d bits=%h: got %h v=%0d e=%0d want %h",
                 k, n, bits, dut_vec(), n_valid - v0, n_err - e0, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc, v0, e0;
    @(negedge clk);
    cs = 1'b0; sck = 1'b0;
    wait_clks(8);
    shift_bits(32'hA5C3, 15, 8, 8);
    rst_n = 1'b0;
    model_reset();
    wait_clks(2);
    checks++;
    if ({dut_vec(), busy_o} !== 53'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got %h busy=%b want 0", dut_vec(), busy_o);
    end
    rst_n = 1'b1;
    v0 = n_valid; e0 = n_err;
    shift_bits(32'hA5C3, 7, 0, 8);
    wait_clks(8);
    cs = 1'b1;
    wait_clks(10);
    checks++;
    if (n_valid != v0 || n_err != e0) begin
      failures++;
      $display("FAIL reset_mid_silent: valid=%0d err=%0d want 0 0", n_valid - v0, n_err - e0);
    end
    send_frame(32'h3FFF, 16, 8, rc);
    model_frame(32'h3FFF, 16);
    wait_clks(4);
    checks++;
    if (dut_vec() !== model_vec() || n_valid - v0 != 1) begin
      failures++;
      $display("FAIL reset_mid_next: got %h valid=%0d want %h valid=1", dut_vec(), n_valid - v0, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_length_err();
    test_shutdown();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
